// File: rtl/inst_fetch_buffer.sv
// Instruction-fetch front end: sequential PC generation, ROM read handshake,
// and a PC-tagged instruction FIFO toward decode with flush-based redirection.
module inst_fetch_buffer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ROM_MSB  = 28,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hBFC00000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              read_ce,
  output logic [ADDR_W-1:0] irom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  input  logic              rfin_c,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
  logic [ADDR_W-1:0] req_pc, req_pc_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic              push, pop, space;
  logic [ADDR_W-1:0] head_pc_n;
  logic [DATA_W-1:0] head_inst_n;

  // irom_addr is a slice of req_pc, so it holds steady for the whole request
  assign irom_addr = ADDR_W'(req_pc[ROM_MSB:2]);

  // FIFO bookkeeping; flush empties the queue outright
  always_comb begin
    push     = (state == REQ) && rfin_c && !flush;
    pop      = inst_valid && inst_ready;
    count_n  = count + CNT_W'(push) - CNT_W'(pop);
    space    = count_n < CNT_W'(DEPTH);
    rd_ptr_n = rd_ptr + PTR_W'(pop);
    wr_ptr_n = wr_ptr + PTR_W'(push);
    if (flush) begin
      count_n  = '0;
      rd_ptr_n = '0;
      wr_ptr_n = '0;
    end
  end

  // Next-state and fetch/request PC update
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_pc_n   = req_pc;
    unique case (state)
      IDLE: begin
        if (ce && !flush && space) begin
          state_n  = REQ;
          req_pc_n = fetch_pc;
        end
      end
      REQ: begin
        if (flush) begin
          state_n = rfin_c ? IDLE : DROP;
        end else if (rfin_c) begin
          fetch_pc_n = req_pc + ADDR_W'(4);
          if (ce && space) req_pc_n = req_pc + ADDR_W'(4);
          else             state_n  = IDLE;
        end
      end
      DROP: begin
        // the outstanding response ends the drop even if another flush arrives
        if (rfin_c) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush) fetch_pc_n = flush_pc & ~ADDR_W'(3);
  end

  // Head of queue next cycle; a push into an empty-after-pop FIFO bypasses memory
  always_comb begin
    head_pc_n   = '0;
    head_inst_n = '0;
    if (count_n != '0) begin
      if (push && (count == CNT_W'(pop))) begin
        head_pc_n   = req_pc;
        head_inst_n = rom_inst;
      end else begin
        head_pc_n   = pc_mem[rd_ptr_n];
        head_inst_n = inst_mem[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      read_ce    <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_n;
      fetch_pc   <= fetch_pc_n;
      req_pc     <= req_pc_n;
      count      <= count_n;
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      read_ce    <= (state_n != IDLE);
      inst_valid <= (count_n != '0);
      inst       <= head_inst_n;
      inst_pc    <= head_pc_n;
    end
  end

  // Queue storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= rom_inst;
    end
  end

endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Parametrised instruction-fetch front end for the MIPS core. It generates sequential fetch addresses from a reset PC and runs a read-enable/read-finish handshake with the instruction ROM. Returned words are queued, tagged with their PC, in a DEPTH-entry FIFO and presented to decode through a valid/ready handshake. Branch redirection is handled by a flush that discards queued words and any in-flight response.

## Interface
Parameters:
- ADDR_W, 32, PC and ROM address width
- DATA_W, 32, instruction width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ROM_MSB, 28, highest PC bit forwarded to ROM address
- RESET_PC, 32'hBFC00000, first fetch address after reset

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- ce  in  1  fetch enable; gates issue of new ROM requests only
- flush  in  1  redirect request, highest priority
- flush_pc  in  ADDR_W  redirect target; bits [1:0] forced to 0
- read_ce  out  1  ROM read request, held until rfin_c
- irom_addr  out  ADDR_W  word address = zero-extend(req_pc[ROM_MSB:2])
- rom_inst  in  DATA_W  ROM data, valid in the cycle rfin_c=1
- rfin_c  in  1  ROM read finish, one cycle per request
- inst_valid  out  1  FIFO non-empty
- inst_ready  in  1  decode accepts head entry
- inst  out  DATA_W  head instruction; 0 when inst_valid=0
- inst_pc  out  ADDR_W  head PC; 0 when inst_valid=0

## Operation
- Registers: fetch_pc (next address to request), req_pc (address of the in-flight request), FIFO of {pc, inst}, count (0..DEPTH), 2-bit state.
- States: IDLE (no request), REQ (request in flight, response kept), DROP (request in flight, response discarded).
- read_ce = 1 in REQ or DROP, else 0. irom_addr always derives from req_pc, so it is stable for the whole request.
- IDLE→REQ when ce=1, flush=0 and count_next < DEPTH. On that transition req_pc<=fetch_pc.
- REQ with rfin_c=1 and no flush:
  - push {req_pc, rom_inst}; fetch_pc<=req_pc+4.
  - If ce=1 and count_next < DEPTH, reissue back-to-back: stay in REQ with req_pc<=req_pc+4.
  - Otherwise go to IDLE.
- REQ with rfin_c=0 stays in REQ.
- Pop: inst_valid and inst_ready both 1. Push and pop in the same cycle leave count unchanged. count_next is count after this cycle's push and pop.
- Overflow is impossible: at most one request is outstanding, and it is issued only with free space.
- flush=1 (overrides everything):
  - FIFO cleared (count<=0); fetch_pc<=flush_pc&~3.
  - From IDLE, stay IDLE; issue next cycle.
  - From REQ with rfin_c=0, go to DROP.
  - From REQ with rfin_c=1, the response is discarded and the state goes to IDLE.
  - From DROP, stay in DROP; the latest flush_pc wins.
- DROP with rfin_c=1: discard rom_inst and go to IDLE; no push.
- ce=0: an outstanding request still completes and pushes; no new issue. The FIFO still drains.
- PC arithmetic is modulo 2^ADDR_W; wrap-around is permitted.

## Timing
- Reset (rst=0 at edge) sets: state IDLE, count 0, fetch_pc=req_pc=RESET_PC, read_ce 0, inst_valid 0, inst 0, inst_pc 0, irom_addr = mapped RESET_PC (32'h07F00000 at defaults).
- Reset mid-request abandons it; read_ce is 0 the next cycle.
- Issue latency: ce=1 in IDLE at edge N gives read_ce=1 from N+1.
- Response latency: rfin_c=1 at edge K gives the entry visible (inst_valid=1 if it was empty) from K+1.
- Throughput with rfin_c held high and inst_ready high: one instruction per cycle.
- Flush at edge F: inst_valid=0 from F+1. Its first request issues at F+1 from IDLE, or one cycle after the dropped rfin_c.

## Test plan
- Reset, ce=1, ROM answers rfin_c one cycle after each read_ce → irom_addr 07F00000, 07F00001, …; inst_pc BFC00000, BFC00004, … with matching words.
- inst_ready=0, continuous rfin_c → exactly DEPTH(4) pushes, read_ce=0, count=4. One pop then restarts a single fetch.
- flush (flush_pc=80001002) while in REQ, rfin_c 3 cycles later → read_ce held and irom_addr unchanged through DROP, word discarded, next request 00000400, inst_pc 80001000.
- flush coincident with rfin_c → no push, FIFO empty next cycle, next request at flush target.
- ce dropped mid-request → in-flight word pushed, no further read_ce until ce=1.
- rst=0 asserted during REQ → all outputs return to their reset values on the next edge; the late rfin_c is ignored.
